sseg_scan: RTL and testbench
============================

// Module: sseg_scan
// PURPOSE
//  Time-multiplexed scan controller for the Nexys2 4-digit 7-segment display.
//  Generates the 2-bit digit select that drives the segment mux.
//  Generates the matching active-low anode enables and active-low decimal point.
//  Inserts a blanking interval at each digit change so the mux output settles before the anode turns on (no ghosting).
// PARAMETERS
//  SLOT_CYCLES   50000  clk cycles per digit slot (1 ms at 50 MHz -> 250 Hz frame); must be > BLANK_CYCLES
//  BLANK_CYCLES  500    cycles at the start of each slot with all anodes off; must be >= 1
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  scan_en     in   1  1 = scan running; 0 = display dark, scan restarts
//  digit_en    in   4  per-digit enable, bit k = digit k (sampled per frame)
//  dp_in       in   4  per-digit decimal point request, active-high (sampled per slot)
//  sel         out  2  current digit index, drives the segment mux select
//  an          out  4  anode enables, active-low, at most one bit low
//  dp_n        out  1  decimal point, active-low
//  frame_tick  out  1  one-cycle pulse in the last cycle of slot 3
// BEHAVIOUR
//  - Reset (async, rst_n=0): sel=0, an=4'b1111, dp_n=1, frame_tick=0, slot counter=0, digit=0, en_q=0, dp_q=0.
//  - All outputs are registered. Cycle 0 of slot 0 is the first rising edge after rst_n rises with scan_en=1.
//  - Slot counter cnt runs 0..SLOT_CYCLES-1. At SLOT_CYCLES-1 it wraps to 0 and the digit advances 0->1->2->3->0.
//  - sel equals the digit for the entire slot and changes only on cnt wrap, i.e. during blanking.
//  - States (per slot):
//    - BLANK (cnt < BLANK_CYCLES): an=4'b1111, dp_n=1.
//    - ON (cnt >= BLANK_CYCLES): an[digit]=0 iff en_q[digit]=1; all other bits 1; dp_n = ~(dp_q & en_q[digit]).
//  - en_q loads digit_en on entry to cycle 0 of slot 0, i.e. once per frame. Mid-frame digit_en changes take effect at the next frame.
//  - dp_q loads dp_in[digit] on entry to cycle 0 of every slot.
//  - A disabled digit keeps its slot time and stays dark; slots are never skipped, so the refresh rate is fixed.
//  - frame_tick=1 only in the cycle where digit=3 and cnt=SLOT_CYCLES-1.
//  - scan_en=0 (sampled at clk):
//    - next cycle: an=1111, dp_n=1, frame_tick=0, cnt=0, digit=0, sel=0.
//    - When scan_en returns to 1, the first enabled cycle is cycle 0 of slot 0 (en_q reloads).
//  - Reset mid-slot: outputs go to reset values immediately (async), with no dependence on clk.
//  - Counter width is clog2(SLOT_CYCLES). No illegal digit value is reachable; sel is a plain 2-bit wrap.
// TESTING  (SLOT_CYCLES=8, BLANK_CYCLES=2 for all benches)
//  1. Hold rst_n=0 for 3 clk, then pulse rst_n low mid-ON -> an=1111, sel=0, dp_n=1, frame_tick=0 without waiting for a clk edge.
//  2. digit_en=1111, scan_en=1 from reset -> cycles 0-1 an=1111, cycles 2-7 an=1110, cycles 10-15 an=1101, cycles 18-23 an=1011, cycles 26-31 an=0111; sel=0,1,2,3 per 8 cycles; frame_tick high at cycles 31 and 63 only.
//  3. digit_en=1010 -> an never 1110 or 1011; sel still steps 0..3; an=1101 in cycles 10-15 and an=0111 in cycles 26-31.
//  4. digit_en 1111->0001 at cycle 12 -> frame 0 unchanged; from cycle 32 only digit 0 lights, with an=1110 in cycles 34-39.
//  5. dp_in=0100 -> dp_n=0 only in cycles 18-23 (coincident with an=1011); otherwise dp_n=1.
//  6. scan_en=0 at cycle 13, re-asserted at cycle 20 -> an=1111 and sel=0 from cycle 14; restart gives an=1111 for 2 cycles, then an=1110 for 6 cycles.
//  Assert continuously: never more than one an bit low; an is 1111 whenever cnt < BLANK_CYCLES.

Source files
------------

// File: rtl/sseg_scan.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Steps a digit select through 0..3, one fixed-length slot per digit, and
// drives active-low anodes / decimal point with a blanking gap at the start
// of every slot so the segment mux settles before an anode turns on.
module sseg_scan #(
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic [3:0] digit_en,
  input  logic [3:0] dp_in,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST      = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ON
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0]      en_q, en_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            dp_n_q, dp_n_d;
  logic            ft_q, ft_d;

  // State, counters and registered outputs; async reset darkens the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      digit_q <= '0;
      en_q    <= '0;
      dp_q    <= 1'b0;
      an_q    <= '1;
      dp_n_q  <= 1'b1;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      en_q    <= en_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      dp_n_q  <= dp_n_d;
      ft_q    <= ft_d;
    end
  end

  // Next-state: slot counter, digit stepping, per-frame/per-slot latches,
  // then the output decode of that next state so outputs line up with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    en_d    = en_q;
    dp_d    = dp_q;
    an_d    = '1;
    dp_n_d  = 1'b1;
    ft_d    = 1'b0;

    if (!scan_en) begin
      cnt_d   = '0;
      digit_d = '0;
    end else if (state_q == ST_IDLE) begin
      // First enabled cycle is cycle 0 of slot 0: latch the frame's enables.
      cnt_d   = '0;
      digit_d = '0;
      en_d    = digit_en;
      dp_d    = dp_in[0];
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      dp_d    = dp_in[digit_d];
      if (digit_d == 2'd0) begin
        en_d = digit_en;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (!scan_en) begin
      state_d = ST_IDLE;
    end else if (cnt_d < BLANK_END) begin
      state_d = ST_BLANK;
    end else begin
      state_d = ST_ON;
    end

    if (state_d == ST_ON) begin
      an_d[digit_d] = ~en_d[digit_d];
      dp_n_d        = ~(dp_d & en_d[digit_d]);
    end
    ft_d = (state_d != ST_IDLE) && (digit_d == 2'd3) && (cnt_d == LAST);
  end

  assign sel        = digit_q;
  assign an         = an_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Bench for sseg_scan with 8-cycle slots and 2-cycle blanking.
module tb_sseg_scan;

  logic       clk;
  logic       rst_n;
  logic       scan_en;
  logic [3:0] digit_en;
  logic [3:0] dp_in;
  logic [1:0] sel;
  logic [3:0] an;
  logic       dp_n;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  sseg_scan #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .sel        (sel),
    .an         (an),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] an;
    logic       dp_n;
    logic       ft;
  } exp_t;

  typedef struct {
    int         cycles;
    logic [3:0] en_a;
    logic [3:0] en_b;
    int         sw;
    logic [3:0] dp;
    int         off_from;
    int         off_to;
  } scen_t;

  typedef struct {
    int         scen;
    int         t;
    logic [1:0] sel;
    logic [3:0] an;
    logic       dp_n;
    logic       ft;
  } vec_t;

  scen_t scen [5];
  vec_t  vecs [29];
  exp_t  sb [$];

  logic [1:0] cap_sel [5][64];
  logic [3:0] cap_an  [5][64];
  logic       cap_dp  [5][64];
  logic       cap_ft  [5][64];

  task automatic chk(input string nm, input int t, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %b want %b", nm, t, act, exp);
    end
  endtask

  // Continuous rules: at most one anode low, and dark during blanking.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_an got %b want <=1 low", an);
      end
      if (dut.cnt_q < 2) begin
        checks++;
        if (an !== 4'b1111) begin
          errors++;
          $display("FAIL blank_an got %b want 1111", an);
        end
      end
    end
  end

  task automatic run_scen(input int s);
    scen_t sc;
    int kk;
    logic [3:0] m_en;
    logic m_dp;
    logic sv;
    int slot, c;
    exp_t e, g;
    sc = scen[s];
    kk = -1;
    m_en = '0;
    m_dp = 1'b0;
    for (int t = -1; t < sc.cycles; t++) begin
      sv = (t >= 0) && !(t >= sc.off_from && t <= sc.off_to);
      scan_en  = sv;
      digit_en = (t < sc.sw) ? sc.en_a : sc.en_b;
      dp_in    = sc.dp;
      if (!sv) begin
        kk = -1;
      end else begin
        kk++;
        if (kk % 32 == 0) m_en = digit_en;
        if (kk % 8 == 0) m_dp = dp_in[(kk / 8) % 4];
      end
      if (kk < 0) begin
        e.sel = 2'd0; e.an = 4'b1111; e.dp_n = 1'b1; e.ft = 1'b0;
      end else begin
        slot = (kk / 8) % 4;
        c    = kk % 8;
        e.sel  = 2'(slot);
        e.an   = 4'b1111;
        e.dp_n = 1'b1;
        if (c >= 2 && m_en[slot]) begin
          e.an = ~(4'b0001 << slot);
          e.dp_n = ~m_dp;
        end
        e.ft = (slot == 3) && (c == 7);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("sel", t, {2'b00, sel}, {2'b00, g.sel});
      chk("an", t, an, g.an);
      chk("dp_n", t, {3'b000, dp_n}, {3'b000, g.dp_n});
      chk("frame_tick", t, {3'b000, frame_tick}, {3'b000, g.ft});
      if (t >= 0) begin
        cap_sel[s][t] = sel;
        cap_an[s][t]  = an;
        cap_dp[s][t]  = dp_n;
        cap_ft[s][t]  = frame_tick;
      end
    end
  endtask

  initial begin
    scen[0] = '{64, 4'b1111, 4'b1111, 999, 4'b0000, -1, -1};
    scen[1] = '{40, 4'b1010, 4'b1010, 999, 4'b0000, -1, -1};
    scen[2] = '{48, 4'b1111, 4'b0001, 12,  4'b0000, -1, -1};
    scen[3] = '{32, 4'b1111, 4'b1111, 999, 4'b0100, -1, -1};
    scen[4] = '{40, 4'b1111, 4'b1111, 999, 4'b0000, 14, 20};

    vecs[0]  = '{0, 0,  2'd0, 4'b1111, 1'b1, 1'b0};
    vecs[1]  = '{0, 1,  2'd0, 4'b1111, 1'b1, 1'b0};
    vecs[2]  = '{0, 2,  2'd0, 4'b1110, 1'b1, 1'b0};
    vecs[3]  = '{0, 7,  2'd0, 4'b1110, 1'b1, 1'b0};
    vecs[4]  = '{0, 8,  2'd1, 4'b1111, 1'b1, 1'b0};
    vecs[5]  = '{0, 10, 2'd1, 4'b1101, 1'b1, 1'b0};
    vecs[6]  = '{0, 18, 2'd2, 4'b1011, 1'b1, 1'b0};
    vecs[7]  = '{0, 26, 2'd3, 4'b0111, 1'b1, 1'b0};
    vecs[8]  = '{0, 30, 2'd3, 4'b0111, 1'b1, 1'b0};
    vecs[9]  = '{0, 31, 2'd3, 4'b0111, 1'b1, 1'b1};
    vecs[10] = '{0, 32, 2'd0, 4'b1111, 1'b1, 1'b0};
    vecs[11] = '{0, 63, 2'd3, 4'b0111, 1'b1, 1'b1};
    vecs[12] = '{1, 2,  2'd0, 4'b1111, 1'b1, 1'b0};
    vecs[13] = '{1, 10, 2'd1, 4'b1101, 1'b1, 1'b0};
    vecs[14] = '{1, 18, 2'd2, 4'b1111, 1'b1, 1'b0};
    vecs[15] = '{1, 26, 2'd3, 4'b0111, 1'b1, 1'b0};
    vecs[16] = '{2, 10, 2'd1, 4'b1101, 1'b1, 1'b0};
    vecs[17] = '{2, 34, 2'd0, 4'b1110, 1'b1, 1'b0};
    vecs[18] = '{2, 42, 2'd1, 4'b1111, 1'b1, 1'b0};
    vecs[19] = '{3, 17, 2'd2, 4'b1111, 1'b1, 1'b0};
    vecs[20] = '{3, 18, 2'd2, 4'b1011, 1'b0, 1'b0};
    vecs[21] = '{3, 24, 2'd3, 4'b1111, 1'b1, 1'b0};
    vecs[22] = '{4, 13, 2'd1, 4'b1101, 1'b1, 1'b0};
    vecs[23] = '{4, 14, 2'd0, 4'b1111, 1'b1, 1'b0};
    vecs[24] = '{4, 20, 2'd0, 4'b1111, 1'b1, 1'b0};
    vecs[25] = '{4, 22, 2'd0, 4'b1111, 1'b1, 1'b0};
    vecs[26] = '{4, 23, 2'd0, 4'b1110, 1'b1, 1'b0};
    vecs[27] = '{4, 28, 2'd0, 4'b1110, 1'b1, 1'b0};
    vecs[28] = '{4, 29, 2'd1, 4'b1111, 1'b1, 1'b0};

    rst_n = 1'b0;
    scan_en = 1'b0;
    digit_en = '0;
    dp_in = '0;

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", 0, {2'b00, sel}, 4'd0);
    chk("rst_an", 0, an, 4'b1111);
    chk("rst_dp_n", 0, {3'b000, dp_n}, 4'd1);
    chk("rst_ft", 0, {3'b000, frame_tick}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 5; s++) run_scen(s);

    for (int i = 0; i < 29; i++) begin
      chk("vec_sel", vecs[i].t, {2'b00, cap_sel[vecs[i].scen][vecs[i].t]}, {2'b00, vecs[i].sel});
      chk("vec_an", vecs[i].t, cap_an[vecs[i].scen][vecs[i].t], vecs[i].an);
      chk("vec_dp_n", vecs[i].t, {3'b000, cap_dp[vecs[i].scen][vecs[i].t]}, {3'b000, vecs[i].dp_n});
      chk("vec_ft", vecs[i].t, {3'b000, cap_ft[vecs[i].scen][vecs[i].t]}, {3'b000, vecs[i].ft});
    end

    // Asynchronous reset in the middle of an ON phase of slot 1.
    scan_en = 1'b0;
    @(posedge clk);
    #1;
    scan_en = 1'b1;
    digit_en = 4'b1111;
    dp_in = 4'b0010;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_an", 11, an, 4'b1101);
    chk("pre_rst_dp_n", 11, {3'b000, dp_n}, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 0, an, 4'b1111);
    chk("async_rst_sel", 0, {2'b00, sel}, 4'd0);
    chk("async_rst_dp_n", 0, {3'b000, dp_n}, 4'd1);
    chk("async_rst_ft", 0, {3'b000, frame_tick}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_c0_an", 0, an, 4'b1111);
    chk("post_rst_c0_sel", 0, {2'b00, sel}, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_c2_an", 2, an, 4'b1110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
